// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and constants for the LC-3 SRAM memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam int   DEFAULT_WAIT_CYCLES = 2;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_register.sv
`default_nettype none
// ============================================================================
// Module      : Register
// Description : N-bit load-enabled holding register, synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module Register #(
    parameter int N = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load,
    input  logic [N-1:0] In,
    output logic [N-1:0] Out
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out <= '0;
        end else if (Load) begin
            Out <= In;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : MAR/MDR memory responder sequencing an async SRAM cycle with
//               WAIT_CYCLES wait states and a one-cycle ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int N           = 16,
    parameter int AW          = 16,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          MIO_EN,
    input  logic          RW,
    input  logic [AW-1:0] Addr,
    input  logic [N-1:0]  WData,
    output logic [N-1:0]  RData,
    output logic          R,
    output logic          Busy,
    output logic [AW-1:0] SRAM_ADDR,
    output logic          SRAM_CE_N,
    output logic          SRAM_OE_N,
    output logic          SRAM_WE_N,
    output logic [N-1:0]  SRAM_DQ_OUT,
    output logic          SRAM_DQ_OE,
    input  logic [N-1:0]  SRAM_DQ_IN
);

    generate
        if (WAIT_CYCLES < 1) begin : g_wait_check
            $error("mem_ctrl: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    localparam int                 c_CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WAIT_CYCLES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rw;
    logic               w_accept;
    logic               w_cnt_done;
    logic               w_read_done;
    logic               w_reg_rst;

    assign w_accept    = (r_state == IDLE) && MIO_EN;
    assign w_cnt_done  = (r_cnt == '0);
    assign w_read_done = (r_state == ACCESS) && w_cnt_done && (r_rw == MEM_READ);
    assign w_reg_rst   = ~Reset;
    assign Busy        = (r_state != IDLE);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request fields are captured only on acceptance so MAR/MDR may move freely afterwards.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_cnt       <= '0;
            r_rw        <= MEM_READ;
            SRAM_ADDR   <= '0;
            SRAM_DQ_OUT <= '0;
        end else begin
            if (w_accept) begin
                SRAM_ADDR   <= Addr;
                r_rw        <= RW;
                SRAM_DQ_OUT <= WData;
            end
            if (r_state == SETUP) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == ACCESS) && !w_cnt_done) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        SRAM_CE_N    = 1'b1;
        SRAM_OE_N    = 1'b1;
        SRAM_WE_N    = 1'b1;
        SRAM_DQ_OE   = 1'b0;
        R            = 1'b0;
        case (r_state)
            IDLE: begin
                if (MIO_EN) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                SRAM_CE_N    = 1'b0;
                SRAM_DQ_OE   = (r_rw == MEM_WRITE);
                w_next_state = ACCESS;
            end
            ACCESS: begin
                SRAM_CE_N = 1'b0;
                if (r_rw == MEM_WRITE) begin
                    SRAM_WE_N  = 1'b0;
                    SRAM_DQ_OE = 1'b1;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (w_cnt_done) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                R            = 1'b1;
                // Keep driving write data one extra cycle to cover SRAM hold time.
                SRAM_DQ_OE   = (r_rw == MEM_WRITE);
                w_next_state = RELEASE;
            end
            RELEASE: begin
                if (!MIO_EN) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    Register #(
        .N (N)
    ) u_rdata (
        .Clk   (Clk),
        .Reset (w_reg_rst),
        .Load  (w_read_done),
        .In    (SRAM_DQ_IN),
        .Out   (RData)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed, table-driven self-checking bench for mem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MIO_EN;
    logic        RW;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic [15:0] RData;
    logic        R;
    logic        Busy;
    logic [15:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [15:0] SRAM_DQ_OUT;
    logic        SRAM_DQ_OE;
    logic [15:0] SRAM_DQ_IN;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    mem_ctrl #(
        .N           (16),
        .AW          (16),
        .WAIT_CYCLES (2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .MIO_EN      (MIO_EN),
        .RW          (RW),
        .Addr        (Addr),
        .WData       (WData),
        .RData       (RData),
        .R           (R),
        .Busy        (Busy),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .SRAM_DQ_IN  (SRAM_DQ_IN)
    );

    // Async SRAM model: writes commit while WE_N is low, reads are combinational.
    logic [15:0] mem [0:65535];
    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            mem[SRAM_ADDR] <= SRAM_DQ_OUT;
        end
    end
    assign SRAM_DQ_IN = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR] : 16'h0000;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset === 1'b1) begin
            n_cmp++;
            if ((!SRAM_WE_N && !SRAM_OE_N) || (!SRAM_WE_N && (SRAM_CE_N || !SRAM_DQ_OE))) begin
                n_err++;
                $display("FAIL strobe_invariant: we_n=%b oe_n=%b ce_n=%b dq_oe=%b",
                         SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_DQ_OE);
            end
        end
    end

    typedef struct {
        logic        en;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic        dq_oe;
        logic        r;
        logic        busy;
        logic [15:0] sa;
        logic [15:0] dq;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [18];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        MIO_EN = v.en;
        RW     = v.rw;
        Addr   = v.addr;
        WData  = v.wdata;
        step();
        chk($sformatf("v%0d_ce_n", idx),  {15'd0, SRAM_CE_N},  {15'd0, v.ce_n});
        chk($sformatf("v%0d_oe_n", idx),  {15'd0, SRAM_OE_N},  {15'd0, v.oe_n});
        chk($sformatf("v%0d_we_n", idx),  {15'd0, SRAM_WE_N},  {15'd0, v.we_n});
        chk($sformatf("v%0d_dq_oe", idx), {15'd0, SRAM_DQ_OE}, {15'd0, v.dq_oe});
        chk($sformatf("v%0d_r", idx),     {15'd0, R},          {15'd0, v.r});
        chk($sformatf("v%0d_busy", idx),  {15'd0, Busy},       {15'd0, v.busy});
        chk($sformatf("v%0d_addr", idx),  SRAM_ADDR,           v.sa);
        chk($sformatf("v%0d_dqout", idx), SRAM_DQ_OUT,         v.dq);
        chk($sformatf("v%0d_rdata", idx), RData,               v.rd);
    endtask

    initial begin
        int rcount;

        mem[16'h3000] = 16'hBEEF;
        mem[16'h4000] = 16'hDEAD;

        //             en rw addr      wdata     ce oe we dq r  bsy sram_addr dq_out    rdata
        // Read 0x3000; Addr moves to 0x4000 during SETUP and must be ignored.
        tbl[0]  = '{1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 16'h4000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3000, 16'h0000, 16'hBEEF};
        tbl[4]  = '{1'b0, 1'b0, 16'h4000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF};
        tbl[5]  = '{1'b0, 1'b0, 16'h4000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF};
        // Write 0x3001 <= 0x1234; later RW/WData changes must be ignored.
        tbl[6]  = '{1'b1, 1'b1, 16'h3001, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h3001, 16'h1234, 16'hBEEF};
        tbl[7]  = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3001, 16'h1234, 16'hBEEF};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3001, 16'h1234, 16'hBEEF};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h3001, 16'h1234, 16'hBEEF};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3001, 16'h1234, 16'hBEEF};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h1234, 16'hBEEF};
        // Read back 0x3001.
        tbl[12] = '{1'b1, 1'b0, 16'h3001, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3001, 16'h5555, 16'hBEEF};
        tbl[13] = '{1'b0, 1'b0, 16'h3001, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3001, 16'h5555, 16'hBEEF};
        tbl[14] = '{1'b0, 1'b0, 16'h3001, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3001, 16'h5555, 16'hBEEF};
        tbl[15] = '{1'b0, 1'b0, 16'h3001, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3001, 16'h5555, 16'h1234};
        tbl[16] = '{1'b0, 1'b0, 16'h3001, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3001, 16'h5555, 16'h1234};
        tbl[17] = '{1'b0, 1'b0, 16'h3001, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h5555, 16'h1234};

        Reset  = 1'b0;
        MIO_EN = 1'b0;
        RW     = 1'b0;
        Addr   = 16'h0000;
        WData  = 16'h0000;
        step();
        step();
        chk("rst_ce_n",  {15'd0, SRAM_CE_N},  16'h0001);
        chk("rst_oe_n",  {15'd0, SRAM_OE_N},  16'h0001);
        chk("rst_we_n",  {15'd0, SRAM_WE_N},  16'h0001);
        chk("rst_dq_oe", {15'd0, SRAM_DQ_OE}, 16'h0000);
        chk("rst_r",     {15'd0, R},          16'h0000);
        chk("rst_busy",  {15'd0, Busy},       16'h0000);
        chk("rst_rdata", RData,               16'h0000);
        chk("rst_addr",  SRAM_ADDR,           16'h0000);
        Reset = 1'b1;
        step();

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i], i);
        end
        chk("sram_mem_3001", mem[16'h3001], 16'h1234);

        // MIO_EN held high across and after one read: exactly one R pulse.
        MIO_EN = 1'b1;
        RW     = 1'b0;
        Addr   = 16'h3000;
        rcount = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (R) rcount++;
        end
        chk("hold_r_pulses", 16'(rcount), 16'd1);
        chk("hold_busy",     {15'd0, Busy},      16'h0001);
        chk("hold_ce_n",     {15'd0, SRAM_CE_N}, 16'h0001);
        MIO_EN = 1'b0;
        step();
        chk("hold_idle_busy", {15'd0, Busy}, 16'h0000);
        MIO_EN = 1'b1;
        Addr   = 16'h3001;
        step();
        chk("second_accept_busy", {15'd0, Busy},      16'h0001);
        chk("second_accept_ce_n", {15'd0, SRAM_CE_N}, 16'h0000);
        MIO_EN = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("second_done_busy",  {15'd0, Busy}, 16'h0000);
        chk("second_done_rdata", RData,         16'h1234);

        // Reset during the second ACCESS cycle of a write abandons the access.
        MIO_EN = 1'b1;
        RW     = 1'b1;
        Addr   = 16'h3002;
        WData  = 16'hAAAA;
        step();
        MIO_EN = 1'b0;
        step();
        step();
        chk("midrst_pre_we_n", {15'd0, SRAM_WE_N}, 16'h0000);
        Reset = 1'b0;
        step();
        chk("midrst_we_n",  {15'd0, SRAM_WE_N},  16'h0001);
        chk("midrst_ce_n",  {15'd0, SRAM_CE_N},  16'h0001);
        chk("midrst_dq_oe", {15'd0, SRAM_DQ_OE}, 16'h0000);
        chk("midrst_r",     {15'd0, R},          16'h0000);
        chk("midrst_busy",  {15'd0, Busy},       16'h0000);
        chk("midrst_rdata", RData,               16'h0000);
        chk("midrst_addr",  SRAM_ADDR,           16'h0000);
        Reset  = 1'b1;
        rcount = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (R || Busy) rcount++;
        end
        chk("midrst_no_activity", 16'(rcount), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
